fetch_pc_stage: RTL and testbench

//  Instruction-fetch front end. Holds the PC, issues reads to a synchronous instruction

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_skid_fifo.sv | 64 ++++++
 rtl/fetch_pc_stage.sv | 105 ++++++++++
 tb/tb_fetch_pc_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   FETCH_WIDTH / FETCH_RESET_PC / FETCH_PC_STEP : default parameter values
//   FIFO_DEPTH                                   : skid FIFO depth
//   fetch_entry_t                                : one buffered {pc, instr} pair
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam logic [FETCH_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_WIDTH-1:0] FETCH_PC_STEP  = 32'd4;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {pc, instr} pairs.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write an entry at the tail
//   pop      : drop the head entry (caller only pops when count != 0)
//   flush    : discard all entries; a same-cycle pop has already been taken
//              by the consumer, so it needs no special handling
//   head     : current head entry (meaningless while count == 0)
//   count    : number of valid entries, 0..FIFO_DEPTH
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  // Pointers wrap naturally because the depth is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through count, which is reset, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  // The issue logic upstream must never let a push land in a full FIFO
  // unless the head leaves in the same cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch front end: PC register, synchronous instruction-memory
// request (1-cycle read latency), 2-entry skid FIFO and downstream handshake.
//   clk, rst        : clock, asynchronous active-low reset
//   redirect_valid  : taken branch/jump; redirect_pc is the new fetch address
//   imem_req/addr   : memory read request and address
//   imem_rdata      : read data, valid the cycle after the request
//   out_valid/ready : downstream handshake for {out_pc, out_instr}
module fetch_pc_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC),
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(FETCH_PC_STEP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic             started;      // first edge after reset release has passed
  logic [WIDTH-1:0] pc;
  logic             inflight;
  logic [WIDTH-1:0] inflight_pc;

  logic [CNT_W-1:0] count;
  entry_t           head;
  entry_t           push_entry;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  assign pop = out_valid & out_ready;

  // Slots that will be taken after this edge if nothing new is issued:
  // buffered entries plus the response still coming back, minus the head
  // leaving now. Only issue when that leaves room for one more response.
  // NOTE: always_comb assigns every output first, so no path can infer a latch.
  always_comb begin
    occupancy = '0;
    issue     = 1'b0;
    occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    issue     = started && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  end

  assign imem_req  = issue;
  assign imem_addr = pc;

  // A redirect drops the response of last cycle's request (wrong path).
  assign push       = inflight && !redirect_valid;
  assign push_entry = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started     <= 1'b0;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        inflight <= 1'b0;
      end else if (issue) begin
        pc          <= pc + PC_STEP;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  fetch_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .head  (head),
    .count (count)
  );

  // Outputs read as zero while empty so stale storage never leaks out.
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage. Memory model returns addr+0x100.
// Stimulus pushes the expected delivered PCs into a queue; a monitor pops
// and compares on every accepted transfer.
module tb_fetch_pc_stage;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  fetch_pc_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, 1-cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr + 32'h100;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted transfer must match the queue head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got_pc=%h exp=none t=%0t", out_pc, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_pc", out_pc, mon_exp);
        check("sb_instr", out_instr, mon_exp + 32'h100);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: advance past the edge, drive inputs, settle.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    tick();
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  // Release reset between edges; returns in the first cycle that may issue.
  task automatic release_rst(input logic rdy);
    tick();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    tick();
    #1;
  endtask

  // Assert reset between edges and check outputs react without a clock.
  task automatic do_reset(input string tag);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rst_req"},   32'(imem_req),  32'd0);
    check({tag, "_rst_addr"},  imem_addr,      32'h0);
    check({tag, "_rst_pc"},    out_pc,         32'h0);
    check({tag, "_rst_instr"}, out_instr,      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("init_valid", 32'(out_valid), 32'd0);
    check("init_req",   32'(imem_req),  32'd0);
    check("init_addr",  imem_addr,      32'h0);
    check("init_pc",    out_pc,         32'h0);
    check("init_instr", out_instr,      32'h0);

    // 1: streaming with out_ready=1
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
    release_rst(1'b1);
    check("t1_req0",   32'(imem_req),  32'd1);
    check("t1_addr0",  imem_addr,      32'h0);
    check("t1_valid0", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("t1_addr", imem_addr, 32'(k * 4));
    end
    do_reset("t1");

    // 2: back-pressure for 5 cycles
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
    release_rst(1'b0);
    check("t2_addr0", imem_addr, 32'h0);
    cyc(1'b0, '0, 1'b0);
    check("t2_addr1", imem_addr, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      cyc(1'b0, '0, 1'b0);
      check("t2_stall_req", 32'(imem_req),  32'd0);
      check("t2_head_pc",   out_pc,         32'h0);
      check("t2_head_vld",  32'(out_valid), 32'd1);
    end
    check("t2_head_instr", out_instr, 32'h100);
    for (int k = 5; k <= 8; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("t2_resume_addr", imem_addr, 32'(k * 4 - 12));
    end

    // 3: redirect with buffered + inflight entries, no pop
    exp_q.push_back(32'h40);
    cyc(1'b1, 32'h40, 1'b0);
    check("t3_req_in_redirect", 32'(imem_req), 32'd0);
    check("t3_buffered_head",   out_pc,        32'h10);
    cyc(1'b0, '0, 1'b1);
    check("t3_bubble1_valid", 32'(out_valid), 32'd0);
    check("t3_target_addr",   imem_addr,      32'h40);
    check("t3_target_req",    32'(imem_req),  32'd1);
    cyc(1'b0, '0, 1'b1);
    check("t3_bubble2_valid", 32'(out_valid), 32'd0);
    check("t3_addr_next",     imem_addr,      32'h44);
    cyc(1'b0, '0, 1'b1);
    check("t3_valid_back", 32'(out_valid), 32'd1);

    // 4: redirect with a same-cycle pop, then back-to-back redirects
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h500);
    cyc(1'b0, '0, 1'b0);
    check("t4_full_req", 32'(imem_req), 32'd0);
    cyc(1'b1, 32'h200, 1'b1);
    check("t4_pop_head", out_pc,        32'h44);
    check("t4_req",      32'(imem_req), 32'd0);
    cyc(1'b1, 32'h300, 1'b1);
    check("t4_flushed", 32'(out_valid), 32'd0);
    check("t4_req_b2b", 32'(imem_req),  32'd0);
    cyc(1'b1, 32'h500, 1'b1);
    check("t4_req_b2b2", 32'(imem_req), 32'd0);
    cyc(1'b0, '0, 1'b1);
    check("t4_last_wins", imem_addr,     32'h500);
    check("t4_req_after", 32'(imem_req), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check("t4_bubble", 32'(out_valid), 32'd0);

    // 5: address wrap at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
    check("t5_pop_with_redirect", out_pc, 32'h500);
    cyc(1'b0, '0, 1'b1);
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, '0, 1'b1);
    check("t5_addr_wrap", imem_addr, 32'h0);
    cyc(1'b0, '0, 1'b1);
    check("t5_addr_after", imem_addr, 32'h4);
    cyc(1'b0, '0, 1'b1);

    // 6: asynchronous reset mid-stream, then restart at RESET_PC
    do_reset("t6");
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    release_rst(1'b1);
    check("t6_restart_addr", imem_addr,     32'h0);
    check("t6_restart_req",  32'(imem_req), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, '0, 1'b1);
      check("t6_addr", imem_addr, 32'(k * 4));
    end
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
